pool2d_relu: RTL and testbench

- Post-processing stage directly downstream of the conv engine.
- After conv asserts done, this block reads the conv result memory through the conv mo port.
- Applies ReLU, 2x2/stride-2 max-pooling and a shift-then-saturate quantisation to unsigned 8 bits.
- Packs the pooled bytes four per 32-bit word, little-endian, into an internal buffer. This is the same packing the conv mi port accepts, so the buffer can seed the next layer.

---
 rtl/pool2d_relu.sv | 169 ++++++++++++++++
 tb/tb_pool2d_relu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pool2d_relu.sv
// ReLU + 2x2/stride-2 max-pool + shift/saturate stage behind the conv engine.
// Reads conv results through the mo port and packs pooled bytes four per word.
module pool2d_relu #(
    parameter int DSIZE = 1024,
    parameter int OSIZE = 256,
    parameter int SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               result_width,
    input  logic [7:0]               result_height,
    input  logic [7:0]               src_stride,
    output logic [$clog2(DSIZE):0]   src_addr,
    input  logic [31:0]              src_data,
    input  logic [$clog2(OSIZE)-1:0] po_addr,
    output logic [31:0]              po_data,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = $clog2(DSIZE) + 1;
    localparam int OW = $clog2(OSIZE);

    typedef enum logic [1:0] {IDLE, READ, LAST, FIN} state_t;

    state_t             state_q, state_d;
    logic [6:0]         pw_q, pw_d;
    logic [7:0]         stride_q, stride_d;
    logic [6:0]         r_q, r_d, c_q, c_d;
    logic [1:0]         k_q, k_d;
    logic [13:0]        i_q, i_d, n_q, n_d;
    logic signed [31:0] m_q, m_d;
    logic [AW-1:0]      src_addr_q, src_addr_d;
    logic [31:0]        po_data_q, po_data_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic [7:0]         row_idx, col_idx;
    logic [AW-1:0]      rd_addr;
    logic signed [31:0] m_fin, relu_v, shifted;
    logic [7:0]         q_byte;
    logic               wr_en;
    logic [31:0]        mem [OSIZE];

    // Window tap (dy,dx) is taken straight from k: bit 1 selects the row, bit 0 the column.
    always_comb begin
        row_idx = {r_q, k_q[1]};
        col_idx = {c_q, k_q[0]};
        rd_addr = AW'(32'(row_idx) * 32'(stride_q) + 32'(col_idx));
    end

    always_comb begin
        m_fin   = ($signed(src_data) > m_q) ? $signed(src_data) : m_q;
        relu_v  = m_fin[31] ? 32'sd0 : m_fin;
        shifted = relu_v >>> SHIFT;
        q_byte  = (shifted > 32'sd255) ? 8'hFF : shifted[7:0];
        wr_en   = (state_q == LAST) && (int'(i_q >> 2) < OSIZE);
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        pw_d       = pw_q;
        stride_d   = stride_q;
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        i_d        = i_q;
        n_d        = n_q;
        m_d        = m_q;
        src_addr_d = src_addr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pw_d     = 7'(result_width >> 1);
                    stride_d = src_stride;
                    n_d      = 14'(result_width >> 1) * 14'(result_height >> 1);
                    r_d      = '0;
                    c_d      = '0;
                    k_d      = '0;
                    i_d      = '0;
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = (n_d == 14'd0) ? FIN : READ;
                end
            end
            READ: begin
                src_addr_d = rd_addr;
                k_d        = k_q + 2'd1;
                // Data returned during k=1 is the first tap of this window.
                if (k_q == 2'd1) begin
                    m_d = $signed(src_data);
                end else if (k_q != 2'd0) begin
                    m_d = m_fin;
                end
                if (k_q == 2'd3) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                m_d = m_fin;
                i_d = i_q + 14'd1;
                if (c_q == pw_q - 7'd1) begin
                    c_d = '0;
                    r_d = r_q + 7'd1;
                end else begin
                    c_d = c_q + 7'd1;
                end
                state_d = (i_q == n_q - 14'd1) ? FIN : READ;
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        po_data_d = mem[po_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pw_q       <= '0;
            stride_q   <= '0;
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            i_q        <= '0;
            n_q        <= '0;
            m_q        <= '0;
            src_addr_q <= '0;
            po_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pw_q       <= pw_d;
            stride_q   <= stride_d;
            r_q        <= r_d;
            c_q        <= c_d;
            k_q        <= k_d;
            i_q        <= i_d;
            n_q        <= n_d;
            m_q        <= m_d;
            src_addr_q <= src_addr_d;
            po_data_q  <= po_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // NOTE: the buffer is deliberately not reset so it maps onto plain RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[OW'(i_q >> 2)][{i_q[1:0], 3'b000} +: 8] <= q_byte;
        end
    end

    assign src_addr = (state_q == READ) ? rd_addr : src_addr_q;
    assign po_data  = po_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pool2d_relu.sv
// Scoreboard bench for pool2d_relu: two instances (SHIFT=0 and SHIFT=2) share stimulus,
// each fed by its own registered read port on a common result-memory model.
module tb_pool2d_relu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  result_width, result_height, src_stride;
    logic [10:0] src_addr0, src_addr2;
    logic [31:0] src_data0, src_data2;
    logic [7:0]  po_addr;
    logic [31:0] po_data0, po_data2;
    logic        busy0, busy2, done0, done2;

    int total = 0;
    int bad   = 0;

    logic signed [31:0] mem_arr [2048];

    typedef struct {
        string       name;
        bit          chk2;
        logic [31:0] exp0;
        logic [31:0] exp2;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    logic    rd_req = 1'b0;

    pool2d_relu #(.DSIZE(1024), .OSIZE(256), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .result_width(result_width), .result_height(result_height), .src_stride(src_stride),
        .src_addr(src_addr0), .src_data(src_data0),
        .po_addr(po_addr), .po_data(po_data0),
        .busy(busy0), .done(done0)
    );

    pool2d_relu #(.DSIZE(1024), .OSIZE(256), .SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .result_width(result_width), .result_height(result_height), .src_stride(src_stride),
        .src_addr(src_addr2), .src_data(src_data2),
        .po_addr(po_addr), .po_data(po_data2),
        .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        src_data0 <= mem_arr[src_addr0];
        src_data2 <= mem_arr[src_addr2];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: a read request seen at a clock edge is answered by po_data just after it.
    always begin : monitor
        rd_exp_t e;
        @(posedge clk);
        if (rd_req) begin
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got 0x%08h expected no read", po_data0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_s0"}, po_data0, e.exp0);
                if (e.chk2) check({e.name, "_s2"}, po_data2, e.exp2);
            end
        end
    end

    task automatic read_word(input logic [7:0] a, input string nm, input bit chk2,
                             input logic [31:0] e0, input logic [31:0] e2);
        @(negedge clk);
        po_addr = a;
        exp_q.push_back('{nm, chk2, e0, e2});
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // Pulses start, then counts edges after the sampling edge until done is seen.
    task automatic run_pool(input logic [7:0] w, input logic [7:0] h, input logic [7:0] s,
                            input int exp_cyc, input int restart_at, input string nm);
        int cyc;
        @(negedge clk);
        result_width  = w;
        result_height = h;
        src_stride    = s;
        start         = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({nm, "_busy_on"}, 32'(busy0), 32'd1);
        check({nm, "_done_clr"}, 32'(done0), 32'd0);
        cyc = 0;
        while (done0 !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == restart_at);
        end
        start = 1'b0;
        check({nm, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({nm, "_busy_off"}, 32'(busy0), 32'd0);
        check({nm, "_done_s2"}, 32'(done2), 32'd1);
    endtask

    task automatic fill_addr();
        for (int a = 0; a < 2048; a++) mem_arr[a] = a;
    endtask

    // 8x8 image img[i]=i convolved with three kernel rows {1,0,-1}; 5x5 results at stride 8.
    task automatic fill_conv();
        int acc;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                acc = 0;
                for (int ky = 0; ky < 3; ky++) begin
                    for (int kx = 0; kx < 3; kx++) begin
                        acc += ((y + ky) * 8 + x + kx) * (1 - kx);
                    end
                end
                mem_arr[y * 8 + x] = acc;
            end
        end
    endtask

    // 6x2 results, stride 6: window maxima 1000, 2000 and an all -5 window.
    task automatic fill_shift();
        int v [12] = '{1000, -7, 2000, 3, -5, -5, 12, 999, -100, 1500, -5, -5};
        for (int a = 0; a < 12; a++) mem_arr[a] = v[a];
    endtask

    initial begin
        logic [10:0] sa;
        rst_n         = 1'b0;
        start         = 1'b0;
        result_width  = '0;
        result_height = '0;
        src_stride    = '0;
        po_addr       = '0;
        #12;
        check("rst_src_addr", 32'(src_addr0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_po_data_s0", po_data0, 32'd0);
        check("rst_po_data_s2", po_data2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        fill_addr();
        run_pool(8'd4, 8'd4, 8'd8, 21, 0, "addr");
        read_word(8'd0, "addr_w0", 1'b1, 32'h1B190B09, 32'h06060202);

        fill_shift();
        run_pool(8'd6, 8'd2, 8'd6, 16, 0, "shift");
        read_word(8'd0, "shift_w0", 1'b1, 32'h1B00FFFF, 32'h0600FFFA);

        sa = src_addr0;
        run_pool(8'd1, 8'd6, 8'd8, 1, 0, "n0");
        check("n0_src_addr_hold", 32'(src_addr0), 32'(sa));
        read_word(8'd0, "n0_w0", 1'b1, 32'h1B00FFFF, 32'h0600FFFA);

        fill_conv();
        run_pool(8'd5, 8'd5, 8'd8, 21, 8, "conv");
        read_word(8'd0, "conv_w0", 1'b1, 32'h00000000, 32'h00000000);

        fill_addr();
        @(negedge clk);
        result_width  = 8'd8;
        result_height = 8'd4;
        src_stride    = 8'd8;
        start         = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_done", 32'(done0), 32'd0);
        check("midrst_busy_s2", 32'(busy2), 32'd0);
        check("midrst_src_addr", 32'(src_addr0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_pool(8'd8, 8'd4, 8'd8, 41, 0, "rerun");
        read_word(8'd0, "rerun_w0", 1'b1, 32'h0F0D0B09, 32'h03030202);
        read_word(8'd1, "rerun_w1", 1'b1, 32'h1F1D1B19, 32'h07070606);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
